// File: rtl/custom_matrix_decoder.sv
// Receive-side inverse for the two-lane GF(2) nibble transform: holds M, computes
// M^-1 with a sequential Gauss-Jordan engine and decodes byte pairs through a 1-deep output register.
module custom_matrix_decoder (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_we,
  input  logic [1:0] cfg_row,
  input  logic [3:0] cfg_data,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       singular,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data
);

  typedef enum logic [1:0] {ST_IDLE, ST_PIVOT, ST_ELIM} state_t;

  state_t     state_reg, state_next;
  logic [1:0] col_reg, col_next;
  logic [3:0] m_reg   [4];
  logic [3:0] a_reg   [4];
  logic [3:0] a_next  [4];
  logic [3:0] b_reg   [4];
  logic [3:0] b_next  [4];
  logic [3:0] inv_reg [4];
  logic [3:0] inv_next[4];
  logic       inv_valid_reg, inv_valid_next;
  logic       singular_reg, singular_next;
  logic       done_reg, done_next;
  logic       out_valid_reg;
  logic [7:0] out_data_reg;

  logic [3:0] col_bits;
  logic [3:0] piv_cand;
  logic       piv_found;
  logic [1:0] piv_row;
  logic [3:0] elim_a [4];
  logic [3:0] elim_b [4];
  logic [3:0] dec_lo, dec_hi;
  logic       accept;

  // Per-row column bit, elimination result and lane decode (row gi of INV dotted with each lane).
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_row
      assign col_bits[gi] = a_reg[gi][col_reg];
      assign elim_a[gi]   = ((2'(gi) != col_reg) && col_bits[gi]) ? (a_reg[gi] ^ a_reg[col_reg]) : a_reg[gi];
      assign elim_b[gi]   = ((2'(gi) != col_reg) && col_bits[gi]) ? (b_reg[gi] ^ b_reg[col_reg]) : b_reg[gi];
      assign dec_lo[gi]   = ^(inv_reg[gi] & in_data[3:0]);
      assign dec_hi[gi]   = ^(inv_reg[gi] & in_data[7:4]);
    end
  endgenerate

  // Only rows at or below the current column may serve as pivot.
  assign piv_cand  = col_bits & (4'b1111 << col_reg);
  assign piv_found = |piv_cand;

  always_comb begin
    piv_row = col_reg;
    for (int r = 3; r >= 0; r--) begin
      if (piv_cand[r]) piv_row = 2'(r);
    end
  end

  always_comb begin
    state_next     = state_reg;
    col_next       = col_reg;
    a_next         = a_reg;
    b_next         = b_reg;
    inv_next       = inv_reg;
    inv_valid_next = inv_valid_reg;
    singular_next  = singular_reg;
    done_next      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (cfg_we) inv_valid_next = 1'b0;
        if (start) begin
          a_next = m_reg;
          for (int i = 0; i < 4; i++) b_next[i] = 4'(1 << i);
          col_next       = 2'd0;
          singular_next  = 1'b0;
          inv_valid_next = 1'b0;
          state_next     = ST_PIVOT;
        end
      end
      ST_PIVOT: begin
        if (piv_found) begin
          a_next[col_reg] = a_reg[piv_row];
          a_next[piv_row] = a_reg[col_reg];
          b_next[col_reg] = b_reg[piv_row];
          b_next[piv_row] = b_reg[col_reg];
          state_next      = ST_ELIM;
        end else begin
          singular_next = 1'b1;
          done_next     = 1'b1;
          state_next    = ST_IDLE;
        end
      end
      ST_ELIM: begin
        a_next = elim_a;
        b_next = elim_b;
        if (col_reg == 2'd3) begin
          inv_next       = elim_b;
          inv_valid_next = 1'b1;
          done_next      = 1'b1;
          state_next     = ST_IDLE;
        end else begin
          col_next   = col_reg + 2'd1;
          state_next = ST_PIVOT;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy     = (state_reg != ST_IDLE);
  assign done     = done_reg;
  assign singular = singular_reg;
  assign in_ready = inv_valid_reg & (~out_valid_reg | out_ready);
  assign accept   = in_valid & in_ready;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      col_reg       <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        m_reg[i]   <= 4'(1 << i);
        a_reg[i]   <= 4'd0;
        b_reg[i]   <= 4'd0;
        inv_reg[i] <= 4'(1 << i);
      end
      inv_valid_reg <= 1'b1;
      singular_reg  <= 1'b0;
      done_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= 8'd0;
    end else begin
      state_reg     <= state_next;
      col_reg       <= col_next;
      a_reg         <= a_next;
      b_reg         <= b_next;
      inv_reg       <= inv_next;
      inv_valid_reg <= inv_valid_next;
      singular_reg  <= singular_next;
      done_reg      <= done_next;
      // A has already sampled the old M when a start coincides with this write.
      if (cfg_we && (state_reg == ST_IDLE)) m_reg[cfg_row] <= cfg_data;
      if (accept) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= {dec_hi, dec_lo};
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_custom_matrix_decoder.sv
// Directed bench for custom_matrix_decoder: reset passthrough, inversion timing,
// singular detection, backpressure, ignored commands and reset mid-inversion.
module tb_custom_matrix_decoder;

  logic       clk = 1'b0;
  logic       rst, cfg_we, start, in_valid, out_ready;
  logic [1:0] cfg_row;
  logic [3:0] cfg_data;
  logic [7:0] in_data;
  logic       busy, done, singular, in_ready, out_valid;
  logic [7:0] out_data;

  int n_pass = 0;
  int n_total = 0;

  int   busy_cnt, done_at, done_cnt, rdy_busy;
  logic sing_at_done;

  logic [7:0] bp_in  [4] = '{8'hFC, 8'h11, 8'h80, 8'h3C};
  logic [7:0] bp_exp [4] = '{8'hA8, 8'h11, 8'hF0, 8'h28};
  int   sent, recv;
  logic ov_model, exp_ir, acc;

  custom_matrix_decoder dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_row(cfg_row), .cfg_data(cfg_data),
    .start(start), .busy(busy), .done(done), .singular(singular),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic load_rows(input logic [3:0] r0, input logic [3:0] r1,
                           input logic [3:0] r2, input logic [3:0] r3);
    logic [3:0] rows [4];
    rows = '{r0, r1, r2, r3};
    for (int i = 0; i < 4; i++) begin
      cfg_we = 1'b1; cfg_row = 2'(i); cfg_data = rows[i];
      step();
    end
    cfg_we = 1'b0;
  endtask

  // mode 0: undisturbed, 1: cfg_we+start at edge E+4, 2: rst at edge E+5
  task automatic invert_run(input int mode, output int b_cnt, output int d_at,
                            output int d_cnt, output int r_busy, output logic s_done);
    b_cnt = 0; d_at = -1; d_cnt = 0; r_busy = 0; s_done = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (busy) b_cnt++;
      if (busy && in_ready) r_busy++;
      if (done) begin
        d_cnt++;
        d_at   = i;
        s_done = singular;
      end
      if (mode == 1 && i == 3) begin
        cfg_we = 1'b1; cfg_row = 2'd0; cfg_data = 4'hF; start = 1'b1;
      end
      if (mode == 1 && i == 4) begin
        cfg_we = 1'b0; start = 1'b0;
      end
      if (mode == 2 && i == 4) rst = 1'b1;
      if (mode == 2 && i == 5) rst = 1'b0;
      step();
    end
  endtask

  task automatic send(input logic [7:0] d, input logic [7:0] exp, input string tag);
    in_valid = 1'b1; in_data = d; out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, 16'(in_ready), 16'h1);
    step();
    in_valid = 1'b0;
    check({tag, "_out_valid"}, 16'(out_valid), 16'h1);
    check({tag, "_out_data"}, 16'(out_data), 16'(exp));
    $display("xfer %s: in=0x%02h out=0x%02h expect=0x%02h", tag, d, out_data, exp);
    step();
  endtask

  task automatic check_good_run(input string tag);
    check({tag, "_busy_cycles"}, 16'(busy_cnt), 16'd8);
    check({tag, "_done_at"}, 16'(done_at), 16'd8);
    check({tag, "_done_count"}, 16'(done_cnt), 16'd1);
    check({tag, "_ready_while_busy"}, 16'(rdy_busy), 16'd0);
    check({tag, "_singular"}, 16'(sing_at_done), 16'h0);
    check({tag, "_in_ready_after"}, 16'(in_ready), 16'h1);
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cfg_row = 2'd0; cfg_data = 4'd0; in_data = 8'd0;
    step();
    step();
    rst = 1'b0;
    #1;
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_done", 16'(done), 16'h0);
    check("rst_singular", 16'(singular), 16'h0);
    check("rst_out_valid", 16'(out_valid), 16'h0);
    check("rst_out_data", 16'(out_data), 16'h0);
    check("rst_in_ready", 16'(in_ready), 16'h1);
    send(8'h5A, 8'h5A, "passthrough");

    // Upper bidiagonal M; inverse rows are F, E, C, 8.
    load_rows(4'h3, 4'h6, 4'hC, 4'h8);
    check("cfg_clears_ready", 16'(in_ready), 16'h0);
    invert_run(0, busy_cnt, done_at, done_cnt, rdy_busy, sing_at_done);
    check_good_run("inv1");
    send(8'hFC, 8'hA8, "dec_fc");
    send(8'h11, 8'h11, "dec_11");
    send(8'h80, 8'hF0, "dec_80");

    // Backpressure: sink stalls for three cycles mid-stream.
    sent = 0; recv = 0; ov_model = 1'b0;
    for (int cyc = 0; cyc < 20 && recv < 4; cyc++) begin
      in_valid  = (sent < 4);
      in_data   = (sent < 4) ? bp_in[sent] : 8'h00;
      out_ready = !(cyc >= 2 && cyc <= 4);
      #1;
      exp_ir = ~ov_model | out_ready;
      check("bp_in_ready", 16'(in_ready), 16'(exp_ir));
      check("bp_out_valid", 16'(out_valid), 16'(ov_model));
      if (out_valid && recv < 4) begin
        check("bp_out_data", 16'(out_data), 16'(bp_exp[recv]));
        if (out_ready) begin
          $display("xfer bp: out=0x%02h expect=0x%02h", out_data, bp_exp[recv]);
          recv++;
        end
      end
      acc = in_valid & in_ready;
      if (acc) sent++;
      ov_model = acc ? 1'b1 : (out_ready ? 1'b0 : ov_model);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp_sent", 16'(sent), 16'd4);
    check("bp_recv", 16'(recv), 16'd4);
    step();
    check("bp_drained", 16'(out_valid), 16'h0);

    // Commands during a running inversion are dropped.
    invert_run(1, busy_cnt, done_at, done_cnt, rdy_busy, sing_at_done);
    check_good_run("inv_ignore");
    send(8'hFC, 8'hA8, "dec_after_ignore");

    // Idle config write invalidates the inverse until the next run completes.
    load_rows(4'h3, 4'h6, 4'hC, 4'h8);
    step();
    step();
    check("idle_cfg_ready", 16'(in_ready), 16'h0);
    invert_run(0, busy_cnt, done_at, done_cnt, rdy_busy, sing_at_done);
    check_good_run("inv2");

    // Singular matrix: fails at column 1.
    load_rows(4'h3, 4'h3, 4'h4, 4'h8);
    invert_run(0, busy_cnt, done_at, done_cnt, rdy_busy, sing_at_done);
    check("sing_busy_cycles", 16'(busy_cnt), 16'd3);
    check("sing_done_at", 16'(done_at), 16'd3);
    check("sing_done_count", 16'(done_cnt), 16'd1);
    check("sing_flag_at_done", 16'(sing_at_done), 16'h1);
    check("sing_flag_held", 16'(singular), 16'h1);
    check("sing_in_ready", 16'(in_ready), 16'h0);
    load_rows(4'h1, 4'h2, 4'h4, 4'h8);
    check("sing_reload_ready", 16'(in_ready), 16'h0);
    invert_run(0, busy_cnt, done_at, done_cnt, rdy_busy, sing_at_done);
    check_good_run("inv_identity");
    check("sing_cleared", 16'(singular), 16'h0);
    send(8'h5A, 8'h5A, "dec_identity");

    // Reset mid-inversion restores identity passthrough.
    load_rows(4'h3, 4'h6, 4'hC, 4'h8);
    invert_run(2, busy_cnt, done_at, done_cnt, rdy_busy, sing_at_done);
    check("rstmid_busy_cycles", 16'(busy_cnt), 16'd5);
    check("rstmid_done_count", 16'(done_cnt), 16'd0);
    check("rstmid_busy", 16'(busy), 16'h0);
    check("rstmid_singular", 16'(singular), 16'h0);
    check("rstmid_in_ready", 16'(in_ready), 16'h1);
    send(8'hFC, 8'hFC, "dec_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
